// File: rtl/obi_sbr_mem_if.sv
// ============================================================================
//  Module      : obi_sbr_mem_if
//  Description : OBI request/response bundle between a manager and the
//                obi_sbr_mem subordinate. The master modport is the manager
//                side, the slave modport is the subordinate side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface obi_sbr_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Request channel
    logic                      req_i;
    logic                      gnt_o;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic                      we_i;
    logic [DATA_WIDTH/8-1:0]   be_i;
    logic [DATA_WIDTH-1:0]     wdata_i;

    // Response channel
    logic                      rvalid_o;
    logic                      rready_i;
    logic [DATA_WIDTH-1:0]     rdata_o;
    logic                      err_o;

    // Sideband status
    logic [7:0]                err_cnt_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, err_cnt_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, err_o, err_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/obi_sbr_mem.sv
// ============================================================================
//  Module      : obi_sbr_mem
//  Description : OBI subordinate backed by a word-addressed memory. Grants
//                after a programmable stall, returns one response per grant
//                through a single-entry response register, flags
//                out-of-range accesses and keeps a saturating error count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_sbr_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    obi_sbr_mem_if.slave  bus
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    in_range;
    logic                    slot_free;
    logic                    gnt;
    logic                    hs;

    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;
    logic [7:0]              err_cnt;

    // Address decode relative to this subordinate's window
    assign idx       = bus.addr_i - BASE_ADDR;
    assign mem_idx   = idx[IDX_W-1:0];
    assign in_range  = (bus.addr_i >= BASE_ADDR) && (idx < ADDR_WIDTH'(DEPTH));

    // The response register holds one entry; it frees up in the same cycle
    // the manager consumes the pending response.
    assign slot_free = !rvalid || bus.rready_i;
    assign hs        = bus.req_i && gnt;

    // Grant decode: same-cycle grant when no stall is configured, otherwise
    // only from GRANT; never while the response register is occupied.
    always_comb begin
        gnt = 1'b0;
        if (!rst_i) begin
            case (state)
                ST_IDLE:  gnt = (WAIT_CYCLES == 0) && bus.req_i && slot_free;
                ST_GRANT: gnt = bus.req_i && slot_free;
                default:  gnt = 1'b0;
            endcase
        end
    end

    // Stall sequencer: the request cycle counts as the first stall cycle, so
    // GRANT is entered on the edge where the counter would reach zero and
    // gnt first rises WAIT_CYCLES cycles after req.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_i && (WAIT_CYCLES != 0)) begin
                        if (WAIT_CYCLES == 1) begin
                            state <= ST_GRANT;
                        end else begin
                            state <= ST_STALL;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_STALL: begin
                    if (!bus.req_i) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1) begin
                            state <= ST_GRANT;
                        end
                    end
                end
                ST_GRANT: begin
                    if (hs) begin
                        state <= (WAIT_CYCLES == 0) ? ST_GRANT : ST_IDLE;
                    end else if (!bus.req_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte-lane write into the array on an in-range write handshake
    always_ff @(posedge clk_i) begin
        if (hs && bus.we_i && in_range) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (bus.be_i[k]) begin
                    mem[mem_idx][k*8 +: 8] <= bus.wdata_i[k*8 +: 8];
                end
            end
        end
    end

    // Response register: loaded on every handshake, held until consumed,
    // and replaced without a bubble when consume and handshake coincide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid  <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (hs) begin
            rvalid <= 1'b1;
            if (in_range) begin
                rdata <= bus.we_i ? '0 : mem[mem_idx];
                err   <= 1'b0;
            end else begin
                rdata <= '0;
                err   <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end else if (rvalid && bus.rready_i) begin
            rvalid <= 1'b0;
        end
    end

    assign bus.gnt_o     = gnt;
    assign bus.rvalid_o  = rvalid;
    assign bus.rdata_o   = rdata;
    assign bus.err_o     = err;
    assign bus.err_cnt_o = err_cnt;

endmodule

`default_nettype wire
